// File: rtl/rr_arb_mux_if.sv
// Valid/ready bundle for rr_arb_mux: NUM_IN source channels in, one registered channel out.
interface rr_arb_mux_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4
);
  localparam int unsigned SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_ready;
  logic                    sel_override_en;
  logic [SEL_W-1:0]        sel_override;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_src;
  logic                    out_ready;

  modport master (
    output in_valid, in_data, sel_override_en, sel_override, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  in_valid, in_data, sel_override_en, sel_override, out_ready,
    output in_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/rr_arb_mux.sv
// N-input round-robin (or index-forced) arbitrating mux feeding a one-entry output register
// with valid/ready backpressure.
module rr_arb_mux #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4
) (
  input logic         clk,
  input logic         reset,
  rr_arb_mux_if.slave bus
);
  localparam int unsigned SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [NUM_IN-1:0] grant;
  logic [NUM_IN-1:0] ready;
  logic [SEL_W-1:0]  grant_idx;
  logic [WIDTH-1:0]  grant_data;
  logic              load_en;
  logic              xfer;

  logic [SEL_W-1:0]  rr_ptr_q;
  logic              out_valid_q;
  logic [WIDTH-1:0]  out_data_q;
  logic [SEL_W-1:0]  out_src_q;

  assign load_en = !out_valid_q || bus.out_ready;

  always_comb begin : grant_sel
    logic found;
    int   idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    if (bus.sel_override_en) begin
      // Out-of-range forced index grants nothing.
      if (int'(bus.sel_override) < int'(NUM_IN)) begin
        grant_idx               = bus.sel_override;
        grant[bus.sel_override] = bus.in_valid[bus.sel_override];
      end
    end else begin
      // Search starts just after the last winner; the last winner is searched last.
      for (int k = 1; k <= int'(NUM_IN); k++) begin
        idx = (int'(rr_ptr_q) + k) % int'(NUM_IN);
        if (!found && bus.in_valid[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = SEL_W'(idx);
        end
      end
    end
  end

  always_comb begin : data_sel
    grant_data = '0;
    for (int i = 0; i < int'(NUM_IN); i++) begin
      if (grant[i]) grant_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  assign ready = reset ? '0 : (grant & {NUM_IN{load_en}});
  assign xfer  = |(bus.in_valid & ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= SEL_W'(NUM_IN - 1);
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= grant_data;
      out_src_q   <= grant_idx;
      rr_ptr_q    <= grant_idx;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// Table-driven bench for rr_arb_mux: hand-derived in_ready per cycle, scoreboard for out_*.
module tb_rr_arb_mux;
  logic clk;
  logic reset;
  logic reset3;

  rr_arb_mux_if #(.WIDTH(32), .NUM_IN(4)) bus ();
  rr_arb_mux_if #(.WIDTH(32), .NUM_IN(3)) bus3 ();

  rr_arb_mux #(.WIDTH(32), .NUM_IN(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  rr_arb_mux #(.WIDTH(32), .NUM_IN(3)) dut3 (
    .clk   (clk),
    .reset (reset3),
    .bus   (bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic       ov_en;
    logic [1:0] ov;
    logic       ordy;
    logic [3:0] exp_ready;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  src;
  } word_t;

  localparam int NVEC = 25;
  vec_t  tbl [NVEC];
  word_t exp_q [$];
  int    checks   = 0;
  int    failures = 0;
  logic  mv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input int ch, input int row);
    return 32'hA0 + ch + (row << 8);
  endfunction

  initial begin
    word_t w;
    logic  xfer;
    logic  drain;
    bus3.in_valid        = '0;
    bus3.in_data         = '0;
    bus3.sel_override_en = 1'b0;
    bus3.sel_override    = '0;
    bus3.out_ready       = 1'b1;
    reset3               = 1'b1;

    //            rst  valid    ov_en ov     ordy  exp_ready
    tbl[0]  = '{1'b1, 4'b1111, 1'b0, 2'd0, 1'b1, 4'b0000};  // reset held 2 cycles
    tbl[1]  = '{1'b1, 4'b1111, 1'b0, 2'd0, 1'b1, 4'b0000};
    tbl[2]  = '{1'b0, 4'b1111, 1'b0, 2'd0, 1'b1, 4'b0001};  // rr 0,1,2,3,0
    tbl[3]  = '{1'b0, 4'b1111, 1'b0, 2'd0, 1'b1, 4'b0010};
    tbl[4]  = '{1'b0, 4'b1111, 1'b0, 2'd0, 1'b1, 4'b0100};
    tbl[5]  = '{1'b0, 4'b1111, 1'b0, 2'd0, 1'b1, 4'b1000};
    tbl[6]  = '{1'b0, 4'b1111, 1'b0, 2'd0, 1'b1, 4'b0001};
    tbl[7]  = '{1'b0, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000};  // 3-cycle stall
    tbl[8]  = '{1'b0, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000};
    tbl[9]  = '{1'b0, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000};
    tbl[10] = '{1'b0, 4'b1111, 1'b0, 2'd0, 1'b1, 4'b0010};  // resumes at ch1
    tbl[11] = '{1'b0, 4'b1011, 1'b1, 2'd2, 1'b1, 4'b0000};  // forced ch2 invalid
    tbl[12] = '{1'b0, 4'b1111, 1'b1, 2'd2, 1'b1, 4'b0100};
    tbl[13] = '{1'b0, 4'b1000, 1'b1, 2'd3, 1'b1, 4'b1000};  // park ptr at 3
    tbl[14] = '{1'b0, 4'b1010, 1'b0, 2'd0, 1'b1, 4'b0010};  // ch1 before ch3
    tbl[15] = '{1'b0, 4'b1010, 1'b0, 2'd0, 1'b1, 4'b1000};
    tbl[16] = '{1'b0, 4'b0001, 1'b0, 2'd0, 1'b1, 4'b0001};  // lone ch0 full rate
    tbl[17] = '{1'b0, 4'b0001, 1'b0, 2'd0, 1'b1, 4'b0001};
    tbl[18] = '{1'b0, 4'b0001, 1'b0, 2'd0, 1'b1, 4'b0001};
    tbl[19] = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000};  // drain to empty
    tbl[20] = '{1'b0, 4'b0001, 1'b0, 2'd0, 1'b0, 4'b0001};  // empty stage loads despite !ordy
    tbl[21] = '{1'b0, 4'b0010, 1'b0, 2'd0, 1'b0, 4'b0000};  // stalled
    tbl[22] = '{1'b1, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000};  // reset mid-stall
    tbl[23] = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000};  // held word gone
    tbl[24] = '{1'b0, 4'b1111, 1'b0, 2'd0, 1'b1, 4'b0001};  // ptr reset -> ch0

    mv = 1'b0;
    for (int r = 0; r < NVEC; r++) begin
      reset               = tbl[r].rst;
      bus.in_valid        = tbl[r].valid;
      bus.sel_override_en = tbl[r].ov_en;
      bus.sel_override    = tbl[r].ov;
      bus.out_ready       = tbl[r].ordy;
      for (int c = 0; c < 4; c++) bus.in_data[c*32 +: 32] = data_of(c, r);
      #1;
      chk($sformatf("in_ready[%0d]", r), 32'(bus.in_ready), 32'(tbl[r].exp_ready));
      if (mv && exp_q.size() > 0) begin
        chk($sformatf("out_data[%0d]", r), bus.out_data, exp_q[0].data);
        chk($sformatf("out_src[%0d]", r), 32'(bus.out_src), 32'(exp_q[0].src));
      end
      if (tbl[r].rst) begin
        exp_q.delete();
        mv = 1'b0;
      end else begin
        drain = mv && tbl[r].ordy;
        if (drain && exp_q.size() > 0) void'(exp_q.pop_front());
        xfer = |(tbl[r].valid & tbl[r].exp_ready);
        if (xfer) begin
          for (int c = 0; c < 4; c++) begin
            if (tbl[r].exp_ready[c]) begin
              w.data = data_of(c, r);
              w.src  = 2'(c);
            end
          end
          exp_q.push_back(w);
        end
        mv = xfer || (mv && !drain);
      end
      @(posedge clk);
      #1;
      chk($sformatf("out_valid[%0d]", r), 32'(bus.out_valid), 32'(mv));
      if (tbl[r].rst) begin
        chk($sformatf("rst_data[%0d]", r), bus.out_data, 32'h0);
        chk($sformatf("rst_src[%0d]", r), 32'(bus.out_src), 32'h0);
      end
    end

    // Three-channel instance: forced index 3 is out of range.
    @(posedge clk);
    #1;
    reset3               = 1'b0;
    bus3.in_valid        = 3'b111;
    bus3.sel_override_en = 1'b1;
    bus3.sel_override    = 2'd3;
    for (int c = 0; c < 3; c++) bus3.in_data[c*32 +: 32] = 32'h5500 + c;
    #1;
    chk("n3_oor_ready", 32'(bus3.in_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("n3_oor_valid", 32'(bus3.out_valid), 32'h0);
    bus3.sel_override = 2'd2;
    #1;
    chk("n3_ov2_ready", 32'(bus3.in_ready), 32'b100);
    @(posedge clk);
    #1;
    chk("n3_ov2_valid", 32'(bus3.out_valid), 32'h1);
    chk("n3_ov2_src", 32'(bus3.out_src), 32'h2);
    chk("n3_ov2_data", bus3.out_data, 32'h5502);
    bus3.sel_override_en = 1'b0;
    #1;
    chk("n3_rr_wrap_ready", 32'(bus3.in_ready), 32'b001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
